fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
Parametrised fetch stage that generates the sequential PC, reads instruction memory and buffers fetched words in a DEPTH-entry prefetch queue ahead of decode. It is the successor to the single-word fetch: it adds decode backpressure, branch redirect with flush, and halt detection. It sits between the instruction memory (combinational read, memory2c style) and the decode stage.

Parameters:
ADDR_W, 16, PC / memory address width
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries (power of two, >=2)
PC_INC, 2, byte increment per sequential fetch
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; single clock domain, rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  ADDR_W  fetch address (equals current PC)
imem_rd_en  out  1  fetch request this cycle
imem_data  in  INSTR_W  instruction word, valid in the same cycle as imem_addr
imem_ready  in  1  memory accepted the read; 0 = memory stall
instr  out  INSTR_W  instruction at queue head
instr_pc  out  ADDR_W  PC of the head instruction
instr_valid  out  1  head entry valid
dec_ready  in  1  decode accepts head when instr_valid && dec_ready
redirect_en  in  1  branch/jump redirect
redirect_pc  in  ADDR_W  redirect target
halted  out  1  halt word has been consumed by decode

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, count=0, rd/wr ptrs=0, stop_fetch=0, halted=0; hence instr_valid=0, imem_rd_en=1, imem_addr=RESET_PC.
- imem_rd_en = !stop_fetch && !halted && (count<DEPTH || deq); deq = instr_valid && dec_ready.
- Enqueue when imem_rd_en && imem_ready && !redirect_en: write {imem_data, pc} at wr_ptr; pc <= pc+PC_INC, wrapping modulo 2^ADDR_W (0xFFFE+2 -> 0x0000).
- Latency: a word accepted in cycle N appears at the head (if the queue was empty) with instr_valid=1 in cycle N+1. No combinational path from imem_data to instr.
- Simultaneous enqueue and dequeue on a full queue is legal; count is unchanged.
- instr/instr_pc are driven from the head entry; when instr_valid=0 their values are don't-care (the bench must not check them).
- Halt: a fetched word equal to HALT_WORD (all zeros) is enqueued normally and sets stop_fetch; no further fetches occur. When decode dequeues the halt entry, halted <= 1 (sticky until reset or redirect).
- Redirect (highest priority): the queue is flushed (count=0, ptrs=0), pc <= redirect_pc, stop_fetch <= 0, halted <= 0, and no enqueue happens that cycle. A dequeue in the same cycle still completes from decode's view; no other entry survives. Fetching resumes at redirect_pc in the next cycle.
- imem_ready=0: pc holds, no enqueue; the queue continues to drain.
- Reset mid-operation discards all entries immediately and asynchronously.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] (enqueues), perf_flushed[31:0] (valid entries discarded by redirect) and perf_stall[31:0] (cycles with imem_rd_en && !imem_ready). All counters reset to 0 and saturate at 0xFFFFFFFF. When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: HALT_WORD, default ADDR_W/INSTR_W, and a typedef for the queue entry {instr, pc}.
- One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO with push/pop/flush and count. The PC, halt and redirect logic stays in the top level.

Test Plan:
- Memory holds 0x1111, 0x2222, 0x3333, 0x0000 at 0,2,4,6; dec_ready=1 -> decode sees (0x1111,pc 0),(0x2222,2),(0x3333,4),(0x0000,6) on consecutive cycles; halted=1 the cycle after 0x0000 is consumed; imem_rd_en=0 after the halt fetch.
- dec_ready=0 for 10 cycles -> count reaches 4, imem_rd_en=0, pc=8; then dec_ready=1 -> entries drain in order with no loss or duplicate, and fetch resumes at 8 in the same cycle as the first dequeue.
- Queue holding pc 2..8, redirect_en=1 with redirect_pc=0x0100 -> next cycle instr_valid=0 and imem_addr=0x0100; the following head is the word at 0x0100.
- Halt fetched and stopped, then redirect to 0x0040 -> halted=0 and fetching resumes at 0x0040.
- RESET_PC=0xFFFC with sequential fetch -> fetched PCs are 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- imem_ready=0 for 3 cycles mid-stream, then assert rst mid-stream -> pc is held during the stall; on rst, outputs immediately take reset values (instr_valid=0, imem_addr=RESET_PC).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: halt encoding, default widths,
// the prefetch queue entry layout and a saturating counter helper.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;

    localparam logic [DEF_INSTR_W-1:0] HALT_WORD = '0;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with push, pop and a flush that empties it in one cycle.
// Flush wins over push/pop; push on full is accepted only together with a pop.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage carries no reset; an entry is only ever read after a push has written it.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: sequential PC, instruction memory request, prefetch queue, redirect flush
// and halt detection. Optional performance counters are built with FETCH_PERF_CNT_EN.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_rd_en,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               dec_ready,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [INSTR_W-1:0] HALT = INSTR_W'(HALT_WORD);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic              r_stop_fetch;
    logic              r_halted;

    entry_t            w_wr_entry;
    entry_t            w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_deq;
    logic              w_enq;

    assign instr_valid = (w_count != '0);
    assign w_deq       = instr_valid && dec_ready;
    // A full queue may still fetch when decode frees the head in the same cycle.
    assign imem_rd_en  = !r_stop_fetch && !r_halted && (!w_full || w_deq);
    assign w_enq       = imem_rd_en && imem_ready && !redirect_en;
    assign imem_addr   = r_pc;

    assign w_wr_entry.instr = imem_data;
    assign w_wr_entry.pc    = r_pc;

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_enq),
        .i_pop     (w_deq),
        .i_flush   (redirect_en),
        .i_wr_data (w_wr_entry),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full)
    );

    assign instr    = w_head.instr;
    assign instr_pc = w_head.pc;
    assign halted   = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_stop_fetch <= 1'b0;
            r_halted     <= 1'b0;
        end else if (redirect_en) begin
            r_pc         <= redirect_pc;
            r_stop_fetch <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            if (w_enq) begin
                r_pc <= r_pc + ADDR_W'(PC_INC);
                if (imem_data == HALT) begin
                    r_stop_fetch <= 1'b1;
                end
            end
            if (w_deq && (w_head.instr == HALT)) begin
                r_halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_stall;
    logic [31:0] w_flush_n;

    // The head leaving to decode in a redirect cycle is consumed, not discarded.
    assign w_flush_n = redirect_en ? (32'(w_count) - 32'(w_deq)) : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= sat_add32(r_perf_fetched, 32'(w_enq));
            r_perf_flushed <= sat_add32(r_perf_flushed, w_flush_n);
            r_perf_stall   <= sat_add32(r_perf_stall, 32'(imem_rd_en && !imem_ready));
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: directed stimulus pushes expected head entries,
// independent monitors pop and compare on every decode handshake.
module tb_fetch_prefetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr, imem_data, instr, instr_pc, redirect_pc;
    logic        imem_rd_en, imem_ready, instr_valid, dec_ready, redirect_en, halted;

    logic [15:0] imem_addr2, imem_data2, instr2, instr_pc2;
    logic        imem_rd_en2, instr_valid2, halted2;
    logic        dec_ready2   = 1'b1;
    logic        redirect_en2 = 1'b0;
    logic        imem_ready2  = 1'b1;
    logic [15:0] redirect_pc2 = 16'h0000;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int n2 = 0;

    fetch_entry_t sb[$];
    fetch_entry_t sb2[$];

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr[8:1]];
    assign imem_data2 = imem_addr2 ^ 16'hA5A5;

    fetch_prefetch_queue u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_data   (imem_data),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    fetch_prefetch_queue #(.RESET_PC(16'hFFFC)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr2),
        .imem_rd_en  (imem_rd_en2),
        .imem_data   (imem_data2),
        .imem_ready  (imem_ready2),
        .instr       (instr2),
        .instr_pc    (instr_pc2),
        .instr_valid (instr_valid2),
        .dec_ready   (dec_ready2),
        .redirect_en (redirect_en2),
        .redirect_pc (redirect_pc2),
        .halted      (halted2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_exp(input logic [15:0] i_word, input logic [15:0] i_pc);
        fetch_entry_t e;
        e.instr = i_word;
        e.pc    = i_pc;
        sb.push_back(e);
    endtask

    // Main DUT monitor: every decode handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && instr_valid && dec_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_deq_pc", {16'h0, instr_pc}, 32'hDEAD);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                check("deq_instr", {16'h0, instr}, {16'h0, e.instr});
                check("deq_pc", {16'h0, instr_pc}, {16'h0, e.pc});
            end
        end
    end

    // Wrap DUT monitor: only the first four fetched entries are of interest.
    always @(negedge clk) begin
        if (!rst && instr_valid2 && n2 < 4) begin
            fetch_entry_t e;
            n2++;
            if (sb2.size() == 0) begin
                check("wrap_unexpected", {16'h0, instr_pc2}, 32'hDEAD);
            end else begin
                e = sb2.pop_front();
                check("wrap_instr", {16'h0, instr2}, {16'h0, e.instr});
                check("wrap_pc", {16'h0, instr_pc2}, {16'h0, e.pc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        fetch_entry_t w;
        rst         = 1'b1;
        dec_ready   = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h0000;

        // Reset state
        #2;
        check("rst_valid", {31'h0, instr_valid}, 0);
        check("rst_rd_en", {31'h0, imem_rd_en}, 1);
        check("rst_addr", {16'h0, imem_addr}, 32'h0000);
        check("rst_halted", {31'h0, halted}, 0);
        check("rst_addr_wrap", {16'h0, imem_addr2}, 32'hFFFC);
        steps(2);

        w.instr = 16'h5A59; w.pc = 16'hFFFC; sb2.push_back(w);
        w.instr = 16'h5A5B; w.pc = 16'hFFFE; sb2.push_back(w);
        w.instr = 16'hA5A5; w.pc = 16'h0000; sb2.push_back(w);
        w.instr = 16'hA5A7; w.pc = 16'h0002; sb2.push_back(w);

        // Straight-line program ending in the halt word
        push_exp(16'h1111, 16'h0000);
        push_exp(16'h2222, 16'h0002);
        push_exp(16'h3333, 16'h0004);
        push_exp(16'h0000, 16'h0006);
        dec_ready = 1'b1;
        rst       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("run_valid", {31'h0, instr_valid}, 1);
        end
        check("halt_stop_rd_en", {31'h0, imem_rd_en}, 0);
        check("halt_not_yet", {31'h0, halted}, 0);
        step();
        check("halted_set", {31'h0, halted}, 1);
        check("halted_empty", {31'h0, instr_valid}, 0);
        steps(2);
        check("halted_no_fetch", {31'h0, imem_rd_en}, 0);
        check("halted_sticky", {31'h0, halted}, 1);

        // Redirect out of halt
        mem[3]      = 16'h4444;
        dec_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect_en = 1'b0;
        check("unhalt_halted", {31'h0, halted}, 0);
        check("unhalt_addr", {16'h0, imem_addr}, 32'h0040);
        check("unhalt_rd_en", {31'h0, imem_rd_en}, 1);
        check("unhalt_valid", {31'h0, instr_valid}, 0);
        steps(4);
        check("fill40_rd_en", {31'h0, imem_rd_en}, 0);
        check("fill40_addr", {16'h0, imem_addr}, 32'h0048);

        // Backpressure: fill from 0 while decode stalls, then drain
        redirect_en = 1'b1;
        redirect_pc = 16'h0000;
        step();
        redirect_en = 1'b0;
        check("flush_valid", {31'h0, instr_valid}, 0);
        check("flush_addr", {16'h0, imem_addr}, 32'h0000);
        steps(10);
        check("bp_rd_en", {31'h0, imem_rd_en}, 0);
        check("bp_addr", {16'h0, imem_addr}, 32'h0008);
        check("bp_valid", {31'h0, instr_valid}, 1);
        push_exp(16'h1111, 16'h0000);
        push_exp(16'h2222, 16'h0002);
        push_exp(16'h3333, 16'h0004);
        push_exp(16'h4444, 16'h0006);
        push_exp(16'hC004, 16'h0008);
        push_exp(16'hC005, 16'h000A);
        push_exp(16'hC006, 16'h000C);
        push_exp(16'hC007, 16'h000E);
        dec_ready = 1'b1;
        #1;
        check("resume_rd_en", {31'h0, imem_rd_en}, 1);
        check("resume_addr", {16'h0, imem_addr}, 32'h0008);
        steps(8);
        dec_ready = 1'b0;
        check("drain_sb_empty", sb.size(), 0);

        // Redirect with a queue holding pc 2..8 and a same-cycle dequeue
        redirect_en = 1'b1;
        redirect_pc = 16'h0000;
        step();
        redirect_en = 1'b0;
        check("flush2_valid", {31'h0, instr_valid}, 0);
        steps(4);
        push_exp(16'h1111, 16'h0000);
        dec_ready = 1'b1;
        step();
        push_exp(16'h2222, 16'h0002);
        redirect_en = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect_en = 1'b0;
        dec_ready   = 1'b0;
        check("redir_valid", {31'h0, instr_valid}, 0);
        check("redir_addr", {16'h0, imem_addr}, 32'h0100);
        check("redir_rd_en", {31'h0, imem_rd_en}, 1);
        step();
        check("redir_head_valid", {31'h0, instr_valid}, 1);
        push_exp(16'hC080, 16'h0100);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;

        // Memory stall holds the PC, then an asynchronous reset mid-stream
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", {16'h0, imem_addr}, 32'h0104);
        end
        check("stall_valid", {31'h0, instr_valid}, 1);
        imem_ready = 1'b1;
        step();
        check("post_stall_addr", {16'h0, imem_addr}, 32'h0106);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, instr_valid}, 0);
        check("async_rst_addr", {16'h0, imem_addr}, 32'h0000);
        check("async_rst_rd_en", {31'h0, imem_rd_en}, 1);
        check("async_rst_wrap_addr", {16'h0, imem_addr2}, 32'hFFFC);
        check("async_rst_halted2", {31'h0, halted2}, 0);
        steps(2);

        check("final_sb_empty", sb.size(), 0);
        check("wrap_seen", n2, 4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
